// File: rtl/block_output_mux_unit.sv
// Registered note-slot selector: passes the first block_size ROM words and blanks the rest.
// Optional BLOCK_OUTPUT_MUX_CLAMP_EN clamps block_size 5-7 to 4 (otherwise treated as 0).
module block_output_mux_unit #(
    parameter logic [15:0] BLANK_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  block_size,
    input  logic [15:0] f_out0,
    input  logic [15:0] f_out1,
    input  logic [15:0] f_out2,
    input  logic [15:0] f_out3,
    output logic [15:0] note0,
    output logic [15:0] note1,
    output logic [15:0] note2,
    output logic [15:0] note3
);

    logic [2:0]  eff_size;
    logic [15:0] f_out [4];
    logic [15:0] note_d [4];
    logic [15:0] note_q [4];

    assign f_out[0] = f_out0;
    assign f_out[1] = f_out1;
    assign f_out[2] = f_out2;
    assign f_out[3] = f_out3;

    always_comb begin
        if (block_size > 3'd4) begin
`ifdef BLOCK_OUTPUT_MUX_CLAMP_EN
            eff_size = 3'd4;
`else
            eff_size = 3'd0;
`endif
        end else begin
            eff_size = block_size;
        end
    end

    // NOTE: every slot gets a value on every path, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            note_d[i] = (eff_size > 3'(i)) ? f_out[i] : BLANK_VALUE;
        end
    end

    // NOTE: state updates use non-blocking assignments so all slots change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) note_q[i] <= BLANK_VALUE;
        end else begin
            for (int i = 0; i < 4; i++) note_q[i] <= note_d[i];
        end
    end

    assign note0 = note_q[0];
    assign note1 = note_q[1];
    assign note2 = note_q[2];
    assign note3 = note_q[3];

endmodule

// File: tb/tb_block_output_mux_unit.sv
// Directed self-checking bench for block_output_mux_unit; compares the packed note vector
// {note0,note1,note2,note3} against hand-computed values one edge after each stimulus change.
module tb_block_output_mux_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  block_size;
    logic [15:0] f_out0, f_out1, f_out2, f_out3;
    logic [15:0] note0, note1, note2, note3;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] FULL  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] BLANK = 64'h0000_0000_0000_0000;

    always #5 clk = ~clk;

    block_output_mux_unit dut (
        .clk       (clk),
        .rst       (rst),
        .block_size(block_size),
        .f_out0    (f_out0),
        .f_out1    (f_out1),
        .f_out2    (f_out2),
        .f_out3    (f_out3),
        .note0     (note0),
        .note1     (note1),
        .note2     (note2),
        .note3     (note3)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] notes();
        return {note0, note1, note2, note3};
    endfunction

    initial begin
        rst        = 1'b1;
        block_size = 3'd4;
        f_out0 = 16'h1111; f_out1 = 16'h2222; f_out2 = 16'h3333; f_out3 = 16'h4444;

        tick(); check("reset_cycle1", notes(), BLANK);
        tick(); check("reset_cycle2", notes(), BLANK);
        rst = 1'b0;
        tick(); check("reset_release", notes(), FULL);

        block_size = 3'd3; tick(); check("size3", notes(), 64'h1111_2222_3333_0000);
        block_size = 3'd1; tick(); check("size1", notes(), 64'h1111_0000_0000_0000);
        block_size = 3'd2; tick(); check("size2", notes(), 64'h1111_2222_0000_0000);
        block_size = 3'd4; tick(); check("size4", notes(), FULL);

        for (int i = 0; i < 5; i++) begin
            tick(); check($sformatf("hold4_%0d", i), notes(), FULL);
        end
        block_size = 3'd0; tick(); check("size0", notes(), BLANK);

        // Latency: new data must not show before the next edge; blanked slot ignores its input.
        block_size = 3'd2; tick(); check("track_pre", notes(), 64'h1111_2222_0000_0000);
        f_out0 = 16'hABCD; f_out2 = 16'h5555;
        #2; check("track_before_edge", notes(), 64'h1111_2222_0000_0000);
        tick(); check("track_after_edge", notes(), 64'hABCD_2222_0000_0000);

        f_out3 = 16'hxxxx; tick(); check("blank_ignores_x", notes(), 64'hABCD_2222_0000_0000);
        f_out0 = 16'h1111; f_out2 = 16'h3333; f_out3 = 16'h4444;

        // Simultaneous size and data change
        block_size = 3'd3; f_out1 = 16'h7777; tick();
        check("simultaneous", notes(), 64'h1111_7777_3333_0000);
        f_out1 = 16'h2222;

        for (int s = 5; s <= 7; s++) begin
            block_size = 3'(s); tick();
`ifdef BLOCK_OUTPUT_MUX_CLAMP_EN
            check($sformatf("oor_size%0d", s), notes(), FULL);
`else
            check($sformatf("oor_size%0d", s), notes(), BLANK);
`endif
        end

        block_size = 3'd4; tick(); check("midrst_pre", notes(), FULL);
        rst = 1'b1; tick(); check("midrst_pulse", notes(), BLANK);
        rst = 1'b0; tick(); check("midrst_resume", notes(), FULL);
        tick(); check("midrst_stable", notes(), FULL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
